lzc_stream: RTL and testbench



---
 rtl/lzc_pkg.sv | 15 +
 rtl/lzc_word.sv | 31 +++
 rtl/lzc_stream.sv | 133 +++++++++++++
 tb/tb_lzc_stream.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared definitions for the streaming leading-zero counter.
//   MODE_NORMAL / MODE_TURBO : encoding of the mode input (1 or LANES words per beat)
//   state_t                  : frame-level FSM states
package lzc_pkg;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_TURBO  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/lzc_word.sv
// Combinational leading-zero count of a single word.
//   word     : operand, MSB first
//   count    : number of leading zeros, 0..WIDTH
//   all_zero : high when the word contains no set bit
module lzc_word #(
  parameter int WIDTH = 8,
  localparam int CLW  = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] word,
  output logic [CLW-1:0]   count,
  output logic             all_zero
);

  logic hit;

  // Scan from the MSB; the first set bit fixes the count. An all-zero
  // word falls through with count = WIDTH.
  always_comb begin
    count = CLW'(WIDTH);
    hit   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (word[i] && !hit) begin
        count = CLW'(WIDTH - 1 - i);
        hit   = 1'b1;
      end
    end
  end

  assign all_zero = ~|word;

endmodule

// File: rtl/lzc_stream.sv
// Streaming leading-zero counter over a WIDTH*WORD-bit operand delivered
// most significant word first, one word (NORMAL) or LANES words (TURBO)
// per beat. The count is accumulated beat by beat; the operand is never stored.
//   clk, rst_n      : clock, synchronous active-low reset
//   data            : beat payload, lane 0 in the top WIDTH bits
//   ivalid / iready : input handshake
//   mode            : NORMAL/TURBO, sampled on the first beat of a frame
//   zeros           : registered leading-zero count of the finished frame
//   ovalid / oready : output handshake
module lzc_stream
  import lzc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORD  = 4,
  parameter int LANES = 2,
  localparam int CW   = $clog2(WIDTH * WORD) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH*LANES-1:0] data,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic                   mode,
  output logic [CW-1:0]          zeros,
  output logic                   ovalid,
  input  logic                   oready
);

  localparam int CLW  = $clog2(WIDTH) + 1;
  // Counter must hold the post-increment value before the end-of-frame test.
  localparam int CNTW = $clog2(WORD + LANES + 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     acc_reg, acc_next;
  logic              found_reg, found_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic              mode_reg, mode_next;
  logic [CW-1:0]     zeros_reg, zeros_next;

  logic [CLW-1:0]    lane_cnt  [LANES];
  logic              lane_zero [LANES];
  logic [CW-1:0]     chain_acc   [LANES+1];
  logic              chain_found [LANES+1];

  logic              first_beat;
  logic              turbo;
  logic [CNTW-1:0]   cnt_sum;

  // The first beat of a frame starts from a cleared accumulator and uses the
  // live mode input; later beats continue from the registered state.
  assign first_beat     = (state_reg == IDLE);
  assign turbo          = first_beat ? (mode == MODE_TURBO) : (mode_reg == MODE_TURBO);
  assign chain_acc[0]   = first_beat ? '0   : acc_reg;
  assign chain_found[0] = first_beat ? 1'b0 : found_reg;
  assign cnt_sum        = (first_beat ? '0 : cnt_reg)
                        + (turbo ? CNTW'(LANES) : CNTW'(1));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic active;

      lzc_word #(.WIDTH(WIDTH)) u_word (
        .word     (data[WIDTH*(LANES-gi)-1 -: WIDTH]),
        .count    (lane_cnt[gi]),
        .all_zero (lane_zero[gi])
      );

      // Only lane 0 contributes in NORMAL mode. Once a set bit has been
      // seen in an earlier word/lane, later words add nothing.
      assign active             = (gi == 0) || turbo;
      assign chain_acc[gi+1]    = (active && !chain_found[gi])
                                  ? chain_acc[gi] + CW'(lane_cnt[gi])
                                  : chain_acc[gi];
      assign chain_found[gi+1]  = chain_found[gi] | (active & ~lane_zero[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      found_reg <= 1'b0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_NORMAL;
      zeros_reg <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      found_reg <= found_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      zeros_reg <= zeros_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    found_next = found_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    zeros_next = zeros_reg;
    case (state_reg)
      IDLE, COLLECT: begin
        if (ivalid) begin
          acc_next   = chain_acc[LANES];
          found_next = chain_found[LANES];
          cnt_next   = cnt_sum;
          if (state_reg == IDLE) begin
            mode_next = mode;
          end
          if (cnt_sum >= CNTW'(WORD)) begin
            state_next = DONE;
            zeros_next = chain_acc[LANES];
          end else begin
            state_next = COLLECT;
          end
        end
      end
      DONE: begin
        if (oready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign iready = (state_reg != DONE);
  assign ovalid = (state_reg == DONE);
  assign zeros  = zeros_reg;

endmodule

// File: tb/tb_lzc_stream.sv
// Directed self-checking bench for lzc_stream with default parameters
// (WIDTH=8, WORD=4, LANES=2). Inputs change 1ns after a rising edge and
// outputs are sampled at the same point.
module tb_lzc_stream;

  localparam int WIDTH = 8;
  localparam int WORD  = 4;
  localparam int LANES = 2;
  localparam int CW    = $clog2(WIDTH * WORD) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [WIDTH*LANES-1:0] data;
  logic                   ivalid;
  logic                   iready;
  logic                   mode;
  logic [CW-1:0]          zeros;
  logic                   ovalid;
  logic                   oready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lzc_stream #(.WIDTH(WIDTH), .WORD(WORD), .LANES(LANES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .ivalid (ivalid),
    .iready (iready),
    .mode   (mode),
    .zeros  (zeros),
    .ovalid (ovalid),
    .oready (oready)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-24s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, waiting (bounded) for iready, and return 1ns after
  // the edge that accepted it.
  task automatic send_beat(input logic [7:0] w0, input logic [7:0] w1, input logic m);
    int n = 0;
    while (!iready && n < 20) begin
      tick();
      n++;
    end
    if (!iready) begin
      n_vec++;
      n_err++;
      $display("FAIL iready_timeout: observed 0 expected 1");
    end
    data   = {w0, w1};
    mode   = m;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    data   = '0;
    ivalid = 1'b0;
    mode   = 1'b0;
    oready = 1'b1;

    // Reset state
    tick();
    tick();
    check("reset_ovalid", int'(ovalid), 0);
    check("reset_zeros", int'(zeros), 0);
    check("reset_iready", int'(iready), 1);
    rst_n = 1'b1;
    tick();

    // NORMAL, consecutive beats; lane 1 carries junk that must be ignored
    send_beat(8'h00, 8'hA5, 1'b0);
    send_beat(8'h00, 8'h5A, 1'b0);
    send_beat(8'h10, 8'hFF, 1'b0);
    check("n1_no_early_result", int'(ovalid), 0);
    send_beat(8'hFF, 8'h00, 1'b0);
    check("n1_ovalid", int'(ovalid), 1);
    check("n1_zeros", int'(zeros), 19);
    check("n1_iready_done", int'(iready), 0);
    tick();
    check("n1_ovalid_drop", int'(ovalid), 0);
    check("n1_iready_back", int'(iready), 1);

    // NORMAL all zero, then a frame with MSB set (acc/found cleared)
    send_beat(8'h00, 8'hFF, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b0);
    check("n2_zeros_all0", int'(zeros), 32);
    send_beat(8'h80, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    check("n3_ovalid", int'(ovalid), 1);
    check("n3_zeros_msb", int'(zeros), 0);

    // TURBO, two beats
    send_beat(8'h00, 8'h00, 1'b1);
    check("t1_no_early_result", int'(ovalid), 0);
    send_beat(8'h01, 8'h80, 1'b1);
    check("t1_ovalid", int'(ovalid), 1);
    check("t1_zeros", int'(zeros), 23);

    // TURBO with mode dropped on beat 2: frame stays TURBO
    send_beat(8'h00, 8'h00, 1'b1);
    send_beat(8'h01, 8'h80, 1'b0);
    check("t2_ovalid", int'(ovalid), 1);
    check("t2_zeros", int'(zeros), 23);

    // NORMAL with two idle cycles between beats
    tick();
    send_beat(8'h00, 8'h00, 1'b0);
    tick(); tick();
    send_beat(8'h03, 8'h00, 1'b0);
    tick(); tick();
    send_beat(8'hFF, 8'h00, 1'b0);
    tick();
    check("g1_no_early_result", int'(ovalid), 0);
    tick();
    send_beat(8'hFF, 8'h00, 1'b0);
    check("g1_ovalid", int'(ovalid), 1);
    check("g1_zeros", int'(zeros), 14);

    // Backpressure: result held, new beat waits
    tick();
    oready = 1'b0;
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h10, 8'h00, 1'b0);
    send_beat(8'hFF, 8'h00, 1'b0);
    data   = {8'h00, 8'h00};
    mode   = 1'b0;
    ivalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ovalid_held", int'(ovalid), 1);
      check("bp_zeros_held", int'(zeros), 19);
      check("bp_iready_low", int'(iready), 0);
    end
    oready = 1'b1;
    tick();
    check("bp_release_ovalid", int'(ovalid), 0);
    check("bp_release_iready", int'(iready), 1);
    tick();
    ivalid = 1'b0;
    send_beat(8'h01, 8'h00, 1'b0);
    send_beat(8'hFF, 8'h00, 1'b0);
    check("bp_next_no_early", int'(ovalid), 0);
    send_beat(8'hFF, 8'h00, 1'b0);
    check("bp_next_ovalid", int'(ovalid), 1);
    check("bp_next_zeros", int'(zeros), 15);

    // Reset in the middle of a frame
    tick();
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_ovalid", int'(ovalid), 0);
    check("rst_mid_zeros", int'(zeros), 0);
    check("rst_mid_iready", int'(iready), 1);
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b0);
    check("rst_fresh_no_early", int'(ovalid), 0);
    send_beat(8'h01, 8'h00, 1'b0);
    check("rst_fresh_ovalid", int'(ovalid), 1);
    check("rst_fresh_zeros", int'(zeros), 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
